// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ requesters.
// Grants bursts of up to MAX_BURST beats; back-pressure comes from the FIFO full flag.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IDW       = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  beat_cnt;

    logic           any_valid;
    logic           found;
    logic [IDW-1:0] pick_id;
    int unsigned    idx;
    logic           beat;
    logic           burst_end;
    logic           release_burst;
    logic [IDW-1:0] next_ptr;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        any_valid = |req_valid;
        found     = 1'b0;
        pick_id   = '0;
        idx       = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                pick_id = IDW'(idx);
            end
        end
    end

    always_comb begin
        beat          = (state == StGrant) && req_valid[grant_id] && !full;
        burst_end     = (beat_cnt == CW'(MAX_BURST - 1));
        release_burst = beat && (req_last[grant_id] || burst_end);
        next_ptr      = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= StIdle;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_valid) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= StGrant;
                    end
                end
                StGrant: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (release_burst) begin
                            rr_ptr <= next_ptr;
                            state  <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Write path is combinational so full stalls the beat in the same cycle.
    always_comb begin
        busy      = (state == StGrant);
        w_en      = beat;
        req_ready = '0;
        data_in   = '0;
        if (state == StGrant) begin
            req_ready[grant_id] = beat;
            data_in             = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: requester queues drive stimulus, a negedge
// monitor pops the expected-write scoreboard whenever the DUT writes.
module tb_fifo_write_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic            wclk = 1'b0;
    logic            wrst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            full = 1'b0;
    logic            w_en;
    logic [DW-1:0]   data_in;
    logic [1:0]      grant_id;
    logic            busy;

    logic [8:0]      src_q [NR][$];
    logic [NR-1:0]   hold = '0;
    exp_t            exp_q [$];
    int              checks = 0;
    int              errors = 0;

    fifo_write_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (4)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .full     (full),
        .w_en     (w_en),
        .data_in  (data_in),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge wclk) begin
        if (wrst_n) begin
            if (full) chk("full_blocks_write", {27'd0, w_en, req_ready}, 32'd0);
            if (w_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got id=%0d data=%0h, required no write",
                             grant_id, data_in);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_id", 32'(grant_id), 32'(e.id));
                    chk("write_data", 32'(data_in), 32'(e.data));
                    chk("write_ready", 32'(req_ready), 32'(1) << e.id);
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < int'(NR); i++) begin
            if (src_q[i].size() != 0 && !hold[i]) begin
                req_valid[i]            = 1'b1;
                req_last[i]             = src_q[i][0][8];
                req_data[i*DW +: DW]    = src_q[i][0][7:0];
            end else begin
                req_valid[i]            = 1'b0;
                req_last[i]             = 1'b0;
                req_data[i*DW +: DW]    = '0;
            end
        end
    endtask

    task automatic load(input int id, input logic [7:0] data, input logic last, input bit exp);
        exp_t e;
        src_q[id].push_back({last, data});
        if (exp) begin
            e.id   = 2'(id);
            e.data = data;
            exp_q.push_back(e);
        end
        drive();
    endtask

    task automatic run(input int n);
        int fired;
        for (int c = 0; c < n; c++) begin
            @(negedge wclk);
            fired = -1;
            for (int i = 0; i < int'(NR); i++) if (w_en && req_ready[i]) fired = i;
            @(posedge wclk);
            #1;
            if (fired >= 0 && wrst_n) void'(src_q[fired].pop_front());
            drive();
        end
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            run(1);
            budget--;
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        for (int i = 0; i < int'(NR); i++) src_q[i].delete();
        hold = '0;
        full = 1'b0;
        drive();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data", 32'(data_in), 32'd0);
        do_reset();

        // Single requester, 3-beat burst
        load(0, 8'h01, 1'b0, 1'b1);
        load(0, 8'h02, 1'b0, 1'b1);
        load(0, 8'h03, 1'b1, 1'b1);
        chk("single_busy_c0", 32'(busy), 32'd0);
        run(1);
        chk("single_busy_c1", 32'(busy), 32'd1);
        chk("single_grant", 32'(grant_id), 32'd0);
        run(2);
        chk("single_busy_c3", 32'(busy), 32'd1);
        run(1);
        chk("single_idle_c4", 32'(busy), 32'd0);
        drain();

        // Round-robin fairness, one write per grant with a 1-cycle gap
        do_reset();
        load(0, 8'h10, 1'b1, 1'b1);
        load(1, 8'h20, 1'b1, 1'b1);
        load(2, 8'h30, 1'b1, 1'b1);
        load(3, 8'h40, 1'b1, 1'b1);
        load(0, 8'h11, 1'b1, 1'b1);
        run(4);
        chk("rr_two_writes_by_c3", 32'(exp_q.size()), 32'd3);
        run(6);
        chk("rr_done_by_c9", 32'(exp_q.size()), 32'd0);
        chk("rr_idle_after", 32'(busy), 32'd0);
        drain();

        // Burst cap: requester 2 never sets last, requester 3 competing
        do_reset();
        for (int k = 0; k < 4; k++) load(2, 8'hA0 + 8'(k), 1'b0, 1'b1);
        load(3, 8'hB0, 1'b1, 1'b1);
        for (int k = 4; k < 10; k++) load(2, 8'hA0 + 8'(k), 1'b0, 1'b1);
        drain();
        chk("cap_held_busy", 32'(busy), 32'd1);
        chk("cap_held_grant", 32'(grant_id), 32'd2);

        // Back-pressure during a requester 1 burst
        do_reset();
        load(1, 8'hC0, 1'b0, 1'b1);
        load(1, 8'hC1, 1'b0, 1'b1);
        load(1, 8'hC2, 1'b0, 1'b1);
        load(1, 8'hC3, 1'b1, 1'b1);
        run(2);
        full = 1'b1;
        run(3);
        chk("bp_pending", 32'(exp_q.size()), 32'd3);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_grant", 32'(grant_id), 32'd1);
        full = 1'b0;
        drain();

        // Bubble on requester 3, then rr wraps so 0 beats 2
        do_reset();
        load(3, 8'hD0, 1'b0, 1'b1);
        load(3, 8'hD1, 1'b1, 1'b1);
        run(2);
        hold[3] = 1'b1;
        load(0, 8'hF0, 1'b1, 1'b0);
        load(2, 8'hE0, 1'b1, 1'b0);
        run(2);
        chk("bubble_busy", 32'(busy), 32'd1);
        chk("bubble_grant", 32'(grant_id), 32'd3);
        chk("bubble_no_write", 32'(exp_q.size()), 32'd1);
        begin
            exp_t e;
            e.id = 2'd0; e.data = 8'hF0; exp_q.push_back(e);
            e.id = 2'd2; e.data = 8'hE0; exp_q.push_back(e);
        end
        hold[3] = 1'b0;
        drive();
        drain();

        // Asynchronous reset mid-burst
        do_reset();
        load(1, 8'h50, 1'b0, 1'b1);
        load(1, 8'h51, 1'b0, 1'b1);
        load(1, 8'h52, 1'b0, 1'b0);
        load(1, 8'h53, 1'b1, 1'b0);
        run(3);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("midrst_w_en", 32'(w_en), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant", 32'(grant_id), 32'd0);
        chk("midrst_writes", 32'(exp_q.size()), 32'd0);
        src_q[1].delete();
        drive();
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        load(2, 8'h60, 1'b1, 1'b1);
        run(1);
        chk("postrst_grant", 32'(grant_id), 32'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. It shares the FIFO write side between NUM_REQ requesters. Each requester gets a granted burst of up to MAX_BURST beats, ending early on its last flag. The block runs entirely in the write clock domain, drives the FIFO's `w_en`/`data_in`, and applies back-pressure to requesters from the FIFO `full` flag.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, FIFO word width
- MAX_BURST, 4, max beats per grant (1..256)
- IDW, $clog2(NUM_REQ), grant index width (derived)
- One clock; reset is asynchronous and active-low. Ports: `wclk`, `wrst_n`.
- wclk  in  1  write-domain clock, rising edge
- wrst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  marks final beat of requester's burst
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- full  in  1  FIFO full flag (write domain)
- w_en  out  1  FIFO write enable
- data_in  out  DATA_WIDTH  FIFO write data
- grant_id  out  IDW  index of current/last granted requester
- busy  out  1  high while in GRANT

## Operation
- Two-state FSM: IDLE, GRANT.
- Registers: state, grant_id, rr_ptr (IDW), beat_cnt ($clog2(MAX_BURST+1) bits).
- IDLE: if any req_valid, select the first set bit searching from rr_ptr upward, with modulo NUM_REQ wrap. Load it into grant_id, clear beat_cnt, and go to GRANT. Otherwise stay in IDLE.
- GRANT: beat = req_valid[grant_id] & !full.
  - req_ready[grant_id] = w_en = beat.
  - data_in = req_data slice of grant_id.
- Outside GRANT: req_ready = 0, w_en = 0, data_in = 0.
- Each beat increments beat_cnt.
- Release occurs on a beat with req_last[grant_id]=1, or on a beat where beat_cnt == MAX_BURST-1. On release:
  - rr_ptr ← (grant_id+1) mod NUM_REQ.
  - Next state is IDLE.
- The grant is held while the granted requester deasserts valid (bubble) or while full=1. There is no timeout.
- Non-granted requesters' valid/last/data are ignored. Their req_ready stays 0.
- If full rises mid-burst, w_en drops in the same cycle (combinational). No write is lost or duplicated.
- Reset (async, any time): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0. Any in-flight burst is abandoned without a partial write on the reset edge.
- Reset values of outputs: req_ready=0, w_en=0, data_in=0, grant_id=0, busy=0.

## Timing
- Arbitration latency is 1 cycle. A valid sampled in IDLE at edge N gives busy=1 and a possible first beat in cycle N+1.
- In GRANT, throughput is 1 beat/cycle when valid=1 and full=0.
- The release beat is the last cycle in GRANT. The following cycle is IDLE, with a mandatory 1-cycle gap between bursts. The next grant's first beat comes at the earliest 2 cycles after the previous final beat.
- w_en, req_ready and data_in are combinational from registered state plus req_valid/full. There is no registered write path.
- grant_id, busy and rr_ptr change only on wclk edges (or async reset).
- Simultaneous req_last and beat_cnt==MAX_BURST-1 cause a single release with identical behaviour.
- MAX_BURST=1 means every beat releases.

## Test plan
- Reset mid-burst: requester 1 at beat 2 of 4, wrst_n pulsed low off-edge → w_en, req_ready, busy and grant_id are 0 immediately. After release, requester 2 alone is granted first, because rr_ptr=0 and the search from 0 finds 2.
- Single requester: req_valid=4'b0001, 3 beats with last on the third, full=0 → busy high cycles 1..3, w_en high cycles 1..3, data_in matches, grant_id=0, IDLE in cycle 4.
- Round-robin fairness: all four valid continuously, last on every beat → grant order 0,1,2,3,0. Each grant produces 1 write, separated by 1 idle cycle.
- Burst cap: MAX_BURST=4, requester 2 streams 10 beats with last never set, requester 3 also valid → requester 2 writes 4 beats, then requester 3 is granted, then requester 2 resumes.
- Back-pressure: full=1 for 3 cycles during a requester 1 burst → w_en and req_ready[1] are 0 for those cycles. Grant is held and beat_cnt is unchanged. All data is written in order once full=0.
- Bubble plus rr wrap: requester 3 granted, drops valid for 2 cycles then sends last → grant held throughout. rr_ptr wraps to 0, so requester 0 wins over requester 2 when both are valid next.
